// File: rtl/vga_stream_pkg.sv
// Shared constants and types for the VGA pixel-stream capture path.
// Pixel field positions follow the 30-bit {R,G,B} Avalon-ST beat.
package vga_stream_pkg;

    localparam int VGA_WIDTH     = 640;
    localparam int VGA_HEIGHT    = 480;
    localparam int SRC_WIDTH     = 160;
    localparam int SRC_HEIGHT    = 120;
    localparam int NumColourBits = 12;

    localparam int PIX_W      = 30;
    localparam int CHAN_IN_W  = 10;
    localparam int R_MSB      = 29;
    localparam int G_MSB      = 19;
    localparam int B_MSB      = 9;
    localparam int RD_ADDR_W  = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        CAPTURE = 2'd2
    } capture_state_t;

    typedef struct packed {
        logic [CHAN_IN_W-1:0] r;
        logic [CHAN_IN_W-1:0] g;
        logic [CHAN_IN_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/vga_frame_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read
// port. A same-address read and write returns the previous contents.
module capture_ram #(
    parameter int DEPTH  = 19200,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Avalon-ST pixel sink: checks SOP/EOP framing, decimates by SCALE in each
// axis and stores quantised pixels in a capture buffer with a read port.
module vga_frame_capture #(
    parameter int VGA_WIDTH  = 640,
    parameter int VGA_HEIGHT = 480,
    parameter int SCALE      = 4,
    parameter int CHAN_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [29:0]            data,
    input  logic                   startofpacket,
    input  logic                   endofpacket,
    input  logic                   valid,
    output logic                   ready,
    input  logic                   capture_en,
    input  logic [14:0]            rd_addr,
    output logic [3*CHAN_BITS-1:0] rd_data,
    output logic                   frame_done,
    output logic [15:0]            frame_count,
    output logic                   err_sop,
    output logic                   err_eop,
    input  logic                   err_clear
);

    import vga_stream_pkg::*;

    localparam int X_W       = $clog2(VGA_WIDTH);
    localparam int Y_W       = $clog2(VGA_HEIGHT);
    localparam int SL        = $clog2(SCALE);
    localparam int BUF_W     = VGA_WIDTH / SCALE;
    localparam int BUF_H     = VGA_HEIGHT / SCALE;
    localparam int BUF_DEPTH = BUF_W * BUF_H;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);
    localparam int DW        = 3 * CHAN_BITS;

    capture_state_t state, state_n;

    logic [X_W-1:0]    x, x_n;
    logic [Y_W-1:0]    y, y_n;
    logic [BUF_AW-1:0] row_base, row_n;
    logic [BUF_AW-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic              we;
    logic              beat;
    logic              at_origin;
    logic              at_last;
    logic              done_n;
    logic              set_sop;
    logic              set_eop;
    logic              rd_in_range;
    logic              rd_oor_q;
    logic [DW-1:0]     ram_q;
    logic              unused_data;
    pixel_t            pix;

    assign ready       = ~reset;
    assign beat        = valid & ready;
    assign at_origin   = (x == '0) && (y == '0);
    assign at_last     = (x == X_W'(VGA_WIDTH - 1)) &&
                         (y == Y_W'(VGA_HEIGHT - 1));
    assign pix         = pixel_t'(data);
    assign unused_data = ^data;

    assign wr_data = {pix.r[CHAN_IN_W-1 -: CHAN_BITS],
                      pix.g[CHAN_IN_W-1 -: CHAN_BITS],
                      pix.b[CHAN_IN_W-1 -: CHAN_BITS]};

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        row_n   = row_base;
        we      = 1'b0;
        wr_addr = row_base + BUF_AW'(x >> SL);
        done_n  = 1'b0;
        set_sop = 1'b0;
        set_eop = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture_en) begin
                    state_n = HUNT;
                end
            end
            HUNT: begin
                if (!capture_en) begin
                    state_n = IDLE;
                end else if (beat && startofpacket) begin
                    we      = 1'b1;
                    wr_addr = '0;
                    x_n     = X_W'(1);
                    y_n     = '0;
                    row_n   = '0;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (beat) begin
                    if (startofpacket && !at_origin) begin
                        // Restart: this beat becomes pixel (0,0)
                        set_sop = 1'b1;
                        we      = 1'b1;
                        wr_addr = '0;
                        x_n     = X_W'(1);
                        y_n     = '0;
                        row_n   = '0;
                    end else begin
                        we = (x[SL-1:0] == '0) && (y[SL-1:0] == '0);
                        if (at_last || endofpacket) begin
                            done_n  = at_last & endofpacket;
                            set_eop = ~(at_last & endofpacket);
                            x_n     = '0;
                            y_n     = '0;
                            row_n   = '0;
                            state_n = capture_en ? HUNT : IDLE;
                        end else if (x == X_W'(VGA_WIDTH - 1)) begin
                            x_n = '0;
                            y_n = y + Y_W'(1);
                            if (&y[SL-1:0]) begin
                                row_n = row_base + BUF_AW'(BUF_W);
                            end
                        end else begin
                            x_n = x + X_W'(1);
                        end
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            x           <= '0;
            y           <= '0;
            row_base    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_sop     <= 1'b0;
            err_eop     <= 1'b0;
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            row_base    <= row_n;
            frame_done  <= done_n;
            frame_count <= frame_count + 16'(done_n);
            if (set_sop) begin
                err_sop <= 1'b1;
            end else if (err_clear) begin
                err_sop <= 1'b0;
            end
            if (set_eop) begin
                err_eop <= 1'b1;
            end else if (err_clear) begin
                err_eop <= 1'b0;
            end
        end
    end

    assign rd_in_range = rd_addr < RD_ADDR_W'(BUF_DEPTH);

    always_ff @(posedge clk) begin
        rd_oor_q <= ~rd_in_range;
    end

    capture_ram #(
        .DEPTH (BUF_DEPTH),
        .DATA_W(DW),
        .ADDR_W(BUF_AW)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_in_range),
        .rd_addr(rd_addr[BUF_AW-1:0]),
        .rd_data(ram_q)
    );

    assign rd_data = rd_oor_q ? '0 : ram_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 64x32 frame so whole
// frames stream quickly; buffer is 16x8 entries of {R4,G4,B4}.
module tb_vga_frame_capture;

    localparam int W  = 64;
    localparam int H  = 32;
    localparam int S  = 4;
    localparam int BW = W / S;
    localparam int BH = H / S;
    localparam int N  = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;
    logic        capture_en;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_sop;
    logic        err_eop;
    logic        err_clear;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int ready_low = 0;
    int d0;

    always #5 clk = ~clk;

    vga_frame_capture #(
        .VGA_WIDTH (W),
        .VGA_HEIGHT(H),
        .SCALE     (S),
        .CHAN_BITS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .startofpacket(startofpacket),
        .endofpacket  (endofpacket),
        .valid        (valid),
        .ready        (ready),
        .capture_en   (capture_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .err_sop      (err_sop),
        .err_eop      (err_eop),
        .err_clear    (err_clear)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (reset === 1'b0 && ready !== 1'b1) ready_low++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] pix(input int x, input int y,
                                        input logic [9:0] blue);
        logic [9:0] r;
        logic [9:0] g;
        r = 10'(x * 16);
        g = 10'(y * 32);
        return {r, g, blue};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_part(input logic [9:0] blue, input int first,
                             input int last, input int eop_at,
                             input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                int g = 0;
                while (g < 8 && $urandom_range(1, 0) == 1) begin
                    valid = 1'b0;
                    tick(1);
                    g++;
                end
            end
            valid         = 1'b1;
            data          = pix(i % W, i / W, blue);
            startofpacket = (i == 0);
            endofpacket   = (i == eop_at);
            tick(1);
            valid         = 1'b0;
            startofpacket = 1'b0;
            endofpacket   = 1'b0;
        end
    endtask

    task automatic check_buf(input string tag, input logic [3:0] b4);
        for (int i = 0; i < BW * BH; i++) begin
            logic [9:0]  r;
            logic [9:0]  g;
            logic [11:0] e;
            r = 10'((i % BW) * S * 16);
            g = 10'((i / BW) * S * 32);
            e = {r[9:6], g[9:6], b4};
            rd_addr = 15'(i);
            tick(1);
            chk(tag, 32'(rd_data), 32'(e));
        end
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        data          = '0;
        startofpacket = 1'b0;
        endofpacket   = 1'b0;
        valid         = 1'b0;
        capture_en    = 1'b1;
        rd_addr       = '0;
        err_clear     = 1'b0;
        tick(3);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_count", 32'(frame_count), 0);
        chk("rst_err_sop", 32'(err_sop), 0);
        chk("rst_err_eop", 32'(err_eop), 0);
        reset = 1'b0;
        tick(1);
        chk("ready_up", 32'(ready), 1);

        d0 = done_cnt;
        send_part(10'h3FF, 0, N - 1, N - 1, 0);
        tick(2);
        chk("grad_done", 32'(done_cnt - d0), 1);
        chk("grad_count", 32'(frame_count), 1);
        chk("grad_err", 32'({err_sop, err_eop}), 0);
        check_buf("grad_buf", 4'hF);
        rd_addr = 15'(BW * BH);
        tick(1);
        chk("oor_first", 32'(rd_data), 0);
        rd_addr = 15'h7FFF;
        tick(1);
        chk("oor_max", 32'(rd_data), 0);

        d0 = done_cnt;
        send_part(10'h155, 0, N - 2, N - 1, 1);
        tick(2);
        chk("gap_no_early_done", 32'(done_cnt - d0), 0);
        send_part(10'h155, N - 1, N - 1, N - 1, 1);
        tick(2);
        chk("gap_done", 32'(done_cnt - d0), 1);
        chk("gap_count", 32'(frame_count), 2);
        check_buf("gap_buf", 4'h5);

        d0 = done_cnt;
        send_part(10'h0AA, 0, 1000, 1000, 0);
        tick(2);
        chk("eop_early_err", 32'(err_eop), 1);
        chk("eop_early_done", 32'(done_cnt - d0), 0);
        chk("eop_early_count", 32'(frame_count), 2);
        send_part(10'h3FF, 0, N - 1, N - 1, 0);
        tick(2);
        chk("clean_count", 32'(frame_count), 3);
        chk("clean_done", 32'(done_cnt - d0), 1);
        chk("eop_sticky", 32'(err_eop), 1);
        check_buf("clean_buf", 4'hF);
        pulse_clear();
        chk("eop_cleared", 32'(err_eop), 0);

        d0 = done_cnt;
        send_part(10'h155, 0, N - 1, -1, 0);
        tick(2);
        chk("eop_miss_err", 32'(err_eop), 1);
        chk("eop_miss_done", 32'(done_cnt - d0), 0);
        chk("eop_miss_count", 32'(frame_count), 3);
        pulse_clear();

        d0 = done_cnt;
        send_part(10'h155, 0, 1199, -1, 0);
        send_part(10'h0AA, 0, N - 1, N - 1, 0);
        tick(2);
        chk("sop_err", 32'(err_sop), 1);
        chk("sop_done", 32'(done_cnt - d0), 1);
        chk("sop_count", 32'(frame_count), 4);
        chk("sop_no_eop_err", 32'(err_eop), 0);
        check_buf("sop_buf", 4'h2);
        pulse_clear();
        chk("sop_cleared", 32'(err_sop), 0);

        capture_en = 1'b0;
        reset      = 1'b1;
        tick(1);
        chk("rst2_count", 32'(frame_count), 0);
        reset = 1'b0;
        d0 = done_cnt;
        ready_low = 0;
        send_part(10'h155, 0, N - 1, N - 1, 0);
        send_part(10'h155, 0, N - 1, N - 1, 0);
        tick(2);
        chk("off_ready", 32'(ready_low), 0);
        chk("off_count", 32'(frame_count), 0);
        chk("off_done", 32'(done_cnt - d0), 0);
        check_buf("off_buf", 4'h2);

        capture_en = 1'b1;
        tick(1);
        send_part(10'h3FF, 0, 999, N - 1, 0);
        capture_en = 1'b0;
        send_part(10'h3FF, 1000, N - 1, N - 1, 0);
        tick(2);
        chk("f3_count", 32'(frame_count), 1);
        chk("f3_done", 32'(done_cnt - d0), 1);
        send_part(10'h155, 0, N - 1, N - 1, 0);
        tick(2);
        chk("f4_count", 32'(frame_count), 1);
        check_buf("f4_buf", 4'hF);

        capture_en = 1'b1;
        tick(1);
        d0 = done_cnt;
        send_part(10'h155, 0, 1499, N - 1, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst3_count", 32'(frame_count), 0);
        send_part(10'h155, 1500, N - 1, N - 1, 0);
        tick(2);
        chk("rst3_tail_count", 32'(frame_count), 0);
        chk("rst3_tail_done", 32'(done_cnt - d0), 0);
        chk("rst3_tail_err", 32'({err_sop, err_eop}), 0);
        send_part(10'h0AA, 0, N - 1, N - 1, 0);
        tick(2);
        chk("rst3_next_count", 32'(frame_count), 1);
        check_buf("rst3_buf", 4'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Avalon-ST sink: the receiving end of the 640x480, 30-bit RGB pixel stream that the face generator and filter sources produce.
- Checks packet framing (SOP/EOP) and decimates 4x in each axis (keeps the top-left pixel of each 4x4 block).
- Quantises each 10-bit channel to 4 bits and writes the result into a 160x120x12 capture buffer. Software or a downstream module reads the buffer through a synchronous read port.
- Reports completed frames and framing errors.

Parameters:
- VGA_WIDTH, 640, active pixels per line in the incoming stream.
- VGA_HEIGHT, 480, active lines per frame.
- SCALE, 4, decimation factor per axis (power of two).
- CHAN_BITS, 4, stored bits per colour channel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data  in  30  pixel {R[29:20], G[19:10], B[9:0]}.
- startofpacket  in  1  first pixel of frame.
- endofpacket  in  1  last pixel of frame.
- valid  in  1  source has a pixel.
- ready  out  1  sink accepts a pixel.
- capture_en  in  1  level; enables capture of frames.
- rd_addr  in  15  capture buffer read address, 0..19199.
- rd_data  out  12  {R4,G4,B4} at rd_addr, 1-cycle latency.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  16  completed frames, wraps at 65535->0.
- err_sop  out  1  sticky: SOP seen mid-frame.
- err_eop  out  1  sticky: EOP early or missing.
- err_clear  in  1  clears err_sop/err_eop.

Behaviour:
- Accept a beat only when valid && ready. ready = ~reset. No other backpressure.
- Reset values:
  - ready 0 during reset; frame_done 0; frame_count 0; err_sop 0; err_eop 0.
  - x/y counters 0; state HUNT.
  - rd_data is undefined until the first read after reset. Buffer contents are not cleared.
- States:
  - IDLE: capture_en=0. Beats are accepted and discarded; no writes.
  - HUNT: discard beats until an accepted beat has SOP=1. That beat is pixel (0,0); go to CAPTURE.
  - CAPTURE: each accepted beat advances x; at x=VGA_WIDTH-1, x wraps to 0 and y increments.
- Write rule: on an accepted beat with x%SCALE==0 and y%SCALE==0, write buffer[(y/SCALE)*160 + x/SCALE].
  - Write data is {data[29:26], data[19:16], data[9:6]} (truncation, no rounding).
  - The write commits on the clock edge that accepts the beat.
- Address generation uses counters only; no divide or modulo hardware.
- Normal end: the beat at x=639, y=479 with EOP=1.
  - frame_done pulses on the next cycle and frame_count increments.
  - State goes to HUNT, or to IDLE if capture_en=0.
- Early EOP (EOP=1 at any other index in CAPTURE): set err_eop, no frame_done, go to HUNT.
- Missing EOP (last index reached with EOP=0): set err_eop, no frame_done, go to HUNT.
- SOP in CAPTURE at index != (0,0): set err_sop, treat the beat as pixel (0,0), remain in CAPTURE.
  - A beat with SOP and EOP both set is handled by the SOP rule first.
- capture_en falling during CAPTURE: finish the current frame, then go to IDLE.
- capture_en rising in IDLE: go to HUNT. A mid-frame stream is never captured partially.
- err_clear and a new error on the same cycle: the error wins (flag stays 1).
- Read port:
  - rd_data is registered, 1-cycle latency.
  - A read and write to the same address in the same cycle returns the old data.
  - rd_addr >= 19200 returns 0.
- Reset asserted mid-frame: counters and state return to HUNT on the next edge; the partial frame is discarded; frame_count is cleared.

Decomposition:
- Package vga_stream_pkg holds:
  - VGA_WIDTH, VGA_HEIGHT, SRC_WIDTH=160, SRC_HEIGHT=120, NumColourBits=12.
  - The capture state enum capture_state_t {IDLE, HUNT, CAPTURE}.
  - The Avalon-ST pixel bit-field positions.
- Sub-module capture_ram: simple dual-port 19200x12 RAM, one write port and one registered read port, read-old-on-collision. Written so it infers block RAM.

Test Plan:
- Gradient frame: send a full frame with data = {x[9:0], y[9:0], 10'h3FF}, capture_en=1, valid held high.
  - Expect: frame_done once, frame_count=1, buffer[i] = {x[9:6], y[9:6], 4'hF} for x=4*(i%160), y=4*(i/160).
  - Expect: rd_data is valid on the cycle after rd_addr is applied.
- Random valid gaps (50% duty): same frame.
  - Expect: identical buffer contents and frame_done only after the final beat.
- Early EOP: EOP asserted at pixel 1000.
  - Expect: err_eop=1, no frame_done, frame_count unchanged.
  - Then a following clean frame captures correctly and frame_count increments.
- Mid-frame SOP: SOP asserted at pixel 5000, then a full frame follows from that beat.
  - Expect: err_sop=1, frame_done once; buffer matches the restarted frame.
  - After pulsing err_clear: err_sop=0.
- capture_en=0 at power-up with two frames streamed.
  - Expect: ready=1 throughout, no writes (preloaded buffer pattern unchanged), frame_count=0.
  - Deassert capture_en mid-frame 3: frame 3 completes, then frame 4 is ignored.
- Reset pulsed at pixel 200000.
  - Expect: frame_count=0, state HUNT.
  - Remainder of that frame ignored until the next SOP; the following frame captures correctly.
